// File: rtl/move_ctrl.sv
// rtl/move_ctrl.sv - move sequencer driving the PID steering datapath
// Turns to heading, ramps forward speed, counts IR line crossings, ramps down.
module move_ctrl #(
    parameter logic [9:0]  FRWRD_INC = 10'h010,
    parameter logic [9:0]  FRWRD_MAX = 10'h2A0,
    parameter logic [11:0] HDNG_TOL  = 12'h030
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    input  logic [11:0] cmd_hdng,
    input  logic [3:0]  cmd_sqrs,
    output logic        cmd_rdy,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic        moving,
    output logic        err_vld,
    output logic [11:0] error,
    output logic [9:0]  frwrd,
    output logic        mv_done
);

    typedef enum logic [2:0] {IDLE, TURN, RAMP_UP, RAMP_DN, DONE} state_t;

    localparam logic [10:0] FRWRD_MAX_W = {1'b0, FRWRD_MAX};
    localparam logic [9:0]  FRWRD_DEC   = FRWRD_INC << 1;

    state_t      state, state_nxt;
    logic [11:0] dsrd_hdng, dsrd_hdng_nxt;
    logic [4:0]  sq_tgt, sq_tgt_nxt;
    logic [4:0]  sq_cnt, sq_cnt_nxt;
    logic [9:0]  frwrd_nxt;
    logic        cntrIR_ff;

    logic        ir_rise;
    logic [4:0]  sq_cnt_inc;
    logic [11:0] err_mag;
    logic        in_tol;
    logic [10:0] frwrd_up;
    logic [9:0]  frwrd_sat;
    logic [9:0]  frwrd_dn;

    assign error   = heading - dsrd_hdng;
    // Negating 0x800 yields 0x800, so the most negative error is never in tolerance.
    assign err_mag = error[11] ? (~error + 12'd1) : error;
    assign in_tol  = err_mag < HDNG_TOL;

    assign ir_rise    = cntrIR & ~cntrIR_ff;
    assign sq_cnt_inc = sq_cnt + {4'd0, ir_rise};

    assign frwrd_up  = {1'b0, frwrd} + {1'b0, FRWRD_INC};
    assign frwrd_sat = (frwrd_up > FRWRD_MAX_W) ? FRWRD_MAX : frwrd_up[9:0];
    assign frwrd_dn  = (frwrd < FRWRD_DEC) ? 10'd0 : frwrd - FRWRD_DEC;

    assign moving  = (state == TURN) || (state == RAMP_UP) || (state == RAMP_DN);
    assign cmd_rdy = (state == IDLE);
    assign mv_done = (state == DONE);
    assign err_vld = heading_rdy & moving;

    always_comb begin
        state_nxt     = state;
        dsrd_hdng_nxt = dsrd_hdng;
        sq_tgt_nxt    = sq_tgt;
        sq_cnt_nxt    = sq_cnt;
        frwrd_nxt     = frwrd;
        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    dsrd_hdng_nxt = cmd_hdng;
                    sq_tgt_nxt    = {cmd_sqrs, 1'b0};
                    sq_cnt_nxt    = 5'd0;
                    frwrd_nxt     = 10'd0;
                    state_nxt     = TURN;
                end
            end
            TURN: begin
                frwrd_nxt = 10'd0;
                if (heading_rdy && in_tol) begin
                    state_nxt = (sq_tgt != 5'd0) ? RAMP_UP : DONE;
                end
            end
            RAMP_UP: begin
                if (heading_rdy) begin
                    frwrd_nxt = frwrd_sat;
                end
                sq_cnt_nxt = sq_cnt_inc;
                // Square target ends the ramp regardless of heading strobes or speed.
                if (sq_cnt_inc == sq_tgt) begin
                    state_nxt = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (frwrd == 10'd0) begin
                    state_nxt = DONE;
                end else if (heading_rdy) begin
                    frwrd_nxt = frwrd_dn;
                end
            end
            DONE: begin
                frwrd_nxt = 10'd0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dsrd_hdng <= 12'd0;
            sq_tgt    <= 5'd0;
            sq_cnt    <= 5'd0;
            frwrd     <= 10'd0;
            cntrIR_ff <= 1'b0;
        end else begin
            state     <= state_nxt;
            dsrd_hdng <= dsrd_hdng_nxt;
            sq_tgt    <= sq_tgt_nxt;
            sq_cnt    <= sq_cnt_nxt;
            frwrd     <= frwrd_nxt;
            cntrIR_ff <= cntrIR;
        end
    end

endmodule

// File: tb/tb_move_ctrl.sv
// tb/tb_move_ctrl.sv - randomized scoreboard bench for move_ctrl
module tb_move_ctrl;

    localparam int INC = 'h010;
    localparam int MAX = 'h2A0;
    localparam int NO_OFF = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic [11:0] cmd_hdng = 12'd0;
    logic [3:0]  cmd_sqrs = 4'd0;
    logic        cmd_rdy;
    logic [11:0] heading = 12'd0;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic        moving;
    logic        err_vld;
    logic [11:0] error;
    logic [9:0]  frwrd;
    logic        mv_done;

    move_ctrl dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_hdng(cmd_hdng),
        .cmd_sqrs(cmd_sqrs), .cmd_rdy(cmd_rdy), .heading(heading),
        .heading_rdy(heading_rdy), .cntrIR(cntrIR), .moving(moving),
        .err_vld(err_vld), .error(error), .frwrd(frwrd), .mv_done(mv_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;
    int exp_frwrd[$];
    int exp_err[$];
    int exp_done[$];

    int mdl_d = 0;
    int mdl_spd = 0;
    bit mdl_moving = 1'b0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(string name, int act);
        total++;
        $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, act);
    endtask

    // Scoreboard monitor: consumes expectations only when the DUT shows an event.
    initial begin
        int prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = int'(frwrd);
                continue;
            end
            if (int'(frwrd) != prev) begin
                if (exp_frwrd.size() == 0) unexpected("frwrd_change", int'(frwrd));
                else check("frwrd", int'(frwrd), exp_frwrd.pop_front());
                prev = int'(frwrd);
            end
            if (err_vld) begin
                if (exp_err.size() == 0) unexpected("err_vld", int'(error));
                else check("error", int'(error), exp_err.pop_front());
            end
            if (mv_done) begin
                check("moving_at_done", int'(moving), 0);
                if (exp_done.size() == 0) unexpected("mv_done", cyc);
                else check("mv_done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic strobe(int h, bit ir);
        heading = h[11:0];
        heading_rdy = 1'b1;
        if (ir) cntrIR = 1'b1;
        if (mdl_moving) exp_err.push_back((h - mdl_d) & 'hFFF);
        tick();
        heading_rdy = 1'b0;
    endtask

    task automatic up_strobe(bit ir);
        int nxt;
        nxt = mdl_spd + INC;
        if (nxt > MAX) nxt = MAX;
        if (nxt != mdl_spd) exp_frwrd.push_back(nxt);
        mdl_spd = nxt;
        strobe(int'($urandom_range(0, 4095)), ir);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_rdy && n < 300) begin
            tick();
            n++;
        end
        check("idle_reached", int'(cmd_rdy), 1);
    endtask

    task automatic start_move(int d, int sqrs, int fin_off);
        int offs[5];
        int off;
        wait_idle();
        mdl_d = d;
        mdl_spd = 0;
        cmd_hdng = d[11:0];
        cmd_sqrs = sqrs[3:0];
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        mdl_moving = 1'b1;
        check("moving_after_cmd", int'(moving), 1);
        check("cmd_rdy_busy", int'(cmd_rdy), 0);
        offs = '{48, -48, 2048, 256, int'($urandom_range(48, 4048))};
        foreach (offs[i]) begin
            strobe((d + offs[i]) & 'hFFF, 1'b0);
            gap();
        end
        cntrIR = 1'b1;
        repeat (3) tick();
        cntrIR = 1'b0;
        repeat (2) tick();
        off = (fin_off == NO_OFF) ? int'($urandom_range(0, 94)) - 47 : fin_off;
        if (sqrs == 0) exp_done.push_back(cyc + 1);
        strobe((d + off) & 'hFFF, 1'b0);
    endtask

    task automatic run_move(int d, int sqrs, int n_up, bit simul, int fin_off);
        int rem;
        int ns;
        bit last;
        int nxt;
        start_move(d, sqrs, fin_off);
        rem = n_up;
        for (int k = 0; k < 2 * sqrs; k++) begin
            last = (k == 2 * sqrs - 1);
            ns = last ? rem : int'($urandom_range(0, rem));
            rem -= ns;
            for (int s = 0; s < ns; s++) begin
                if (last && simul && s == ns - 1) break;
                up_strobe(1'b0);
                gap();
            end
            if ($urandom_range(0, 1) == 1) begin
                cmd_hdng = 12'($urandom_range(0, 4095));
                cmd_sqrs = 4'($urandom_range(0, 15));
                cmd_vld = 1'b1;
                check("cmd_rdy_ramp", int'(cmd_rdy), 0);
                tick();
                cmd_vld = 1'b0;
            end
            if (last && simul && ns > 0) begin
                up_strobe(1'b1);
            end else begin
                if (last && mdl_spd == 0) exp_done.push_back(cyc + 2);
                cntrIR = 1'b1;
                tick();
            end
            repeat (2) tick();
            cntrIR = 1'b0;
            repeat (2) tick();
        end
        while (mdl_spd > 0) begin
            nxt = (mdl_spd < 2 * INC) ? 0 : mdl_spd - 2 * INC;
            exp_frwrd.push_back(nxt);
            mdl_spd = nxt;
            if (nxt == 0) exp_done.push_back(cyc + 2);
            strobe(int'($urandom_range(0, 4095)), 1'b0);
            gap();
        end
        wait_idle();
        mdl_moving = 1'b0;
    endtask

    task automatic reset_mid_ramp();
        start_move(int'($urandom_range(0, 4095)), 3, 0);
        repeat (8) up_strobe(1'b0);
        repeat (2) tick();
        check("frwrd_pre_reset", int'(frwrd), 'h080);
        #1;
        rst = 1'b1;
        #1;
        check("rst_moving", int'(moving), 0);
        check("rst_frwrd", int'(frwrd), 0);
        check("rst_cmd_rdy", int'(cmd_rdy), 1);
        check("rst_mv_done", int'(mv_done), 0);
        exp_frwrd.delete();
        exp_err.delete();
        exp_done.delete();
        mdl_spd = 0;
        mdl_moving = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #1;
        check("reset_cmd_rdy", int'(cmd_rdy), 1);
        check("reset_moving", int'(moving), 0);
        check("reset_err_vld", int'(err_vld), 0);
        check("reset_frwrd", int'(frwrd), 0);
        check("reset_mv_done", int'(mv_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        strobe('h123, 1'b0);
        run_move('h000, 0, 0, 1'b0, 'h020);
        run_move('hFF0, 0, 0, 1'b0, 'h020);
        run_move('h3A0, 0, 0, 1'b0, 47);
        run_move('h7C5, 0, 0, 1'b0, -47);
        run_move('h100, 3, 50, 1'b0, 0);
        run_move('h250, 2, 6, 1'b0, NO_OFF);
        run_move('h050, 1, 1, 1'b0, NO_OFF);
        run_move('h0A0, 1, 0, 1'b0, NO_OFF);
        run_move('h9F0, 2, 10, 1'b1, NO_OFF);
        reset_mid_ramp();
        for (int m = 0; m < 16; m++) begin
            run_move(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 45)), 1'($urandom_range(0, 1)), NO_OFF);
        end
        strobe('h456, 1'b0);
        repeat (4) tick();
        check("frwrd_queue_empty", exp_frwrd.size(), 0);
        check("err_queue_empty", exp_err.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
